// File: rtl/var_bw_mul_pkg.sv
// rtl/var_bw_mul_pkg.sv - shared constants, lane encoding and tag type for var_bw_mul_sched
// Purpose: widths, lane enum, per-issue tag struct and the lane-to-result helper.
// Ports: none (package).
package var_bw_mul_pkg;

  localparam int LAT      = 2;   // request-to-response latency in cycles, informational only
  localparam int NARROW_W = 8;
  localparam int WIDE_W   = 16;
  localparam int PROD_W   = 32;

  typedef enum logic [1:0] {
    LANE_NONE = 2'd0,
    LANE_LO   = 2'd1,
    LANE_HI   = 2'd2,
    LANE_FULL = 2'd3
  } lane_e;

  typedef struct packed {
    logic  valid;
    lane_e lane0;
    lane_e lane1;
  } tag_t;

  localparam tag_t TAG_IDLE = '{valid: 1'b0, lane0: LANE_NONE, lane1: LANE_NONE};

  // Narrow products occupy a 16-bit half of the product bus and are zero-extended.
  function automatic logic [PROD_W-1:0] lane_result(input lane_e lane, input logic [PROD_W-1:0] p);
    case (lane)
      LANE_FULL: lane_result = p;
      LANE_LO:   lane_result = {16'h0, p[15:0]};
      LANE_HI:   lane_result = {16'h0, p[31:16]};
      default:   lane_result = '0;
    endcase
  endfunction

endpackage

// File: rtl/var_bw_mul_sched_if.sv
// rtl/var_bw_mul_sched_if.sv - client and multiplier bus bundle for var_bw_mul_sched
// Purpose: groups both request/response channels, the multiplier operand/product bus and pair_cnt.
// Ports (modport slave = scheduler side):
//   in : req{0,1}_valid, req{0,1}_wide, req{0,1}_a, req{0,1}_b, mul_p
//   out: req{0,1}_ready, rsp{0,1}_valid, rsp{0,1}_p, mul_para_mode, mul_a, mul_b, pair_cnt
// modport master is the mirror image (clients plus multiplier).
interface var_bw_mul_sched_if;
  import var_bw_mul_pkg::*;

  logic              req0_valid, req0_ready, req0_wide;
  logic [WIDE_W-1:0] req0_a, req0_b;
  logic              req1_valid, req1_ready, req1_wide;
  logic [WIDE_W-1:0] req1_a, req1_b;
  logic              rsp0_valid, rsp1_valid;
  logic [PROD_W-1:0] rsp0_p, rsp1_p;
  logic              mul_para_mode;
  logic [WIDE_W-1:0] mul_a, mul_b;
  logic [PROD_W-1:0] mul_p;
  logic [15:0]       pair_cnt;

  modport slave (
    input  req0_valid, req0_wide, req0_a, req0_b,
    input  req1_valid, req1_wide, req1_a, req1_b,
    input  mul_p,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_p, rsp1_valid, rsp1_p,
    output mul_para_mode, mul_a, mul_b, pair_cnt
  );

  modport master (
    output req0_valid, req0_wide, req0_a, req0_b,
    output req1_valid, req1_wide, req1_a, req1_b,
    output mul_p,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_p, rsp1_valid, rsp1_p,
    input  mul_para_mode, mul_a, mul_b, pair_cnt
  );

endinterface

// File: rtl/var_bw_mul_rr_arb.sv
// rtl/var_bw_mul_rr_arb.sv - two-way round-robin arbiter with pair-grant override
// Purpose: grants one of two requesters per cycle, alternating under contention.
// Ports:
//   clk, rst_n      : clock, async active-low reset
//   req0, req1      : requests present
//   pair            : grant both this cycle; pointer is left untouched
//   gnt0, gnt1      : combinational grants
module var_bw_mul_rr_arb (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic pair,
  output logic gnt0,
  output logic gnt1
);

  logic rr_q;  // 0: req0 preferred, 1: req1 preferred

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (pair) begin
      gnt0 = 1'b1;
      gnt1 = 1'b1;
    end else if (req0 && req1) begin
      gnt0 = !rr_q;
      gnt1 = rr_q;
    end else begin
      gnt0 = req0;
      gnt1 = req1;
    end
  end

  // A single grant hands preference to the other requester; paired or idle cycles keep it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= 1'b0;
    end else if (gnt0 ^ gnt1) begin
      rr_q <= gnt0;
    end
  end

endmodule

// File: rtl/var_bw_mul_sched.sv
// rtl/var_bw_mul_sched.sv - two-requester scheduler for the shared variable bit-width multiplier
// Purpose: arbitrates 8/16-bit multiply requests, packs simultaneous narrow requests into one
//   parallel-mode issue (when VAR_BW_MUL_PAIR_EN is defined), registers operands to the
//   multiplier and registers the product back per requester. Request-to-response latency is 2.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   bus        : var_bw_mul_sched_if.slave (request/response channels, multiplier bus, pair_cnt)
// Configuration: VAR_BW_MUL_PAIR_EN enables narrow pairing and pair_cnt; otherwise pair_cnt is 0.
module var_bw_mul_sched
  import var_bw_mul_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  var_bw_mul_sched_if.slave  bus
);

  logic              pair;
  logic              gnt0, gnt1;
  logic              iss_mode;
  logic [WIDE_W-1:0] iss_a, iss_b;
  tag_t              iss_tag;
  tag_t              tag_q;

`ifdef VAR_BW_MUL_PAIR_EN
  assign pair = bus.req0_valid && bus.req1_valid && !bus.req0_wide && !bus.req1_wide;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.pair_cnt <= '0;
    end else if (pair && (bus.pair_cnt != 16'hFFFF)) begin
      bus.pair_cnt <= bus.pair_cnt + 16'd1;
    end
  end
`else
  assign pair         = 1'b0;
  assign bus.pair_cnt = '0;
`endif

  var_bw_mul_rr_arb u_arb (
    .clk  (clk),
    .rst_n(rst_n),
    .req0 (bus.req0_valid),
    .req1 (bus.req1_valid),
    .pair (pair),
    .gnt0 (gnt0),
    .gnt1 (gnt1)
  );

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;

  // Narrow req0 always rides the low lane and narrow req1 the high lane, so a solo narrow
  // issue and a paired issue share one encoding; the unused lane is zero.
  always_comb begin
    iss_mode      = 1'b1;
    iss_a         = '0;
    iss_b         = '0;
    iss_tag       = TAG_IDLE;
    iss_tag.valid = gnt0 || gnt1;
    if (gnt0) iss_tag.lane0 = bus.req0_wide ? LANE_FULL : LANE_LO;
    if (gnt1) iss_tag.lane1 = bus.req1_wide ? LANE_FULL : LANE_HI;
    if (gnt0 && bus.req0_wide) begin
      iss_mode = 1'b0;
      iss_a    = bus.req0_a;
      iss_b    = bus.req0_b;
    end else if (gnt1 && bus.req1_wide) begin
      iss_mode = 1'b0;
      iss_a    = bus.req1_a;
      iss_b    = bus.req1_b;
    end else begin
      if (gnt0) begin
        iss_a[NARROW_W-1:0] = bus.req0_a[NARROW_W-1:0];
        iss_b[NARROW_W-1:0] = bus.req0_b[NARROW_W-1:0];
      end
      if (gnt1) begin
        iss_a[WIDE_W-1:NARROW_W] = bus.req1_a[NARROW_W-1:0];
        iss_b[WIDE_W-1:NARROW_W] = bus.req1_b[NARROW_W-1:0];
      end
    end
  end

  // Operand and tag stage; operands hold on idle cycles to avoid needless toggling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mul_para_mode <= 1'b0;
      bus.mul_a         <= '0;
      bus.mul_b         <= '0;
      tag_q             <= TAG_IDLE;
    end else begin
      tag_q <= iss_tag;
      if (iss_tag.valid) begin
        bus.mul_para_mode <= iss_mode;
        bus.mul_a         <= iss_a;
        bus.mul_b         <= iss_b;
      end
    end
  end

  // Result stage: each owner picks its lane out of the combinational product.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.rsp0_valid <= 1'b0;
      bus.rsp1_valid <= 1'b0;
      bus.rsp0_p     <= '0;
      bus.rsp1_p     <= '0;
    end else begin
      bus.rsp0_valid <= tag_q.valid && (tag_q.lane0 != LANE_NONE);
      bus.rsp1_valid <= tag_q.valid && (tag_q.lane1 != LANE_NONE);
      bus.rsp0_p     <= lane_result(tag_q.lane0, bus.mul_p);
      bus.rsp1_p     <= lane_result(tag_q.lane1, bus.mul_p);
    end
  end

endmodule

// File: tb/tb_var_bw_mul_sched.sv
// tb/tb_var_bw_mul_sched.sv - scoreboard bench for var_bw_mul_sched
module tb_var_bw_mul_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  var_bw_mul_sched_if bus();

  var_bw_mul_sched dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

`ifdef VAR_BW_MUL_PAIR_EN
  localparam bit PAIR = 1'b1;
`else
  localparam bit PAIR = 1'b0;
`endif

  // Behavioural multiplier: parallel mode gives two independent 8x8 products in the halves.
  function automatic logic [31:0] mul_model(input logic para, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] lo, hi;
    lo = 16'(a[7:0]) * 16'(b[7:0]);
    hi = 16'(a[15:8]) * 16'(b[15:8]);
    mul_model = para ? {hi, lo} : 32'(a) * 32'(b);
  endfunction

  assign bus.mul_p = mul_model(bus.mul_para_mode, bus.mul_a, bus.mul_b);

  // Reference product of a request, straight from its wide/narrow meaning.
  function automatic logic [31:0] ref_prod(input logic w, input logic [15:0] a, input logic [15:0] b);
    ref_prod = w ? 32'(a) * 32'(b) : 32'(a & 16'h00FF) * 32'(b & 16'h00FF);
  endfunction

  typedef struct {
    int          due;
    logic [31:0] p;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pending client requests, the model's preference bit and pair count.
  logic        pv[2], pw[2];
  logic [15:0] pa[2], pb[2];
  logic        rdy[2];
  logic        m_rr = 1'b0;
  int          m_pair = 0;

  // One clock of client activity: drive the held requests, then judge the handshake.
  task automatic cycle();
    logic g0, g1, both, pr;
    @(posedge clk);
    #1;
    bus.req0_valid = pv[0]; bus.req0_wide = pw[0]; bus.req0_a = pa[0]; bus.req0_b = pb[0];
    bus.req1_valid = pv[1]; bus.req1_wide = pw[1]; bus.req1_a = pa[1]; bus.req1_b = pb[1];
    @(negedge clk);
    check("pair_cnt", 32'(bus.pair_cnt), 32'(m_pair));
    both = pv[0] && pv[1];
    pr   = PAIR && both && !pw[0] && !pw[1];
    if (pr) begin
      g0 = 1'b1; g1 = 1'b1;
    end else if (both) begin
      g0 = !m_rr; g1 = m_rr;
    end else begin
      g0 = pv[0]; g1 = pv[1];
    end
    check("req0_ready", 32'(bus.req0_ready), 32'(g0));
    check("req1_ready", 32'(bus.req1_ready), 32'(g1));
    rdy[0] = bus.req0_ready;
    rdy[1] = bus.req1_ready;
    if (g0) begin
      q0.push_back('{due: cyc + 2, p: ref_prod(pw[0], pa[0], pb[0])});
      pv[0] = 1'b0;
    end
    if (g1) begin
      q1.push_back('{due: cyc + 2, p: ref_prod(pw[1], pa[1], pb[1])});
      pv[1] = 1'b0;
    end
    if (pr) m_pair = (m_pair < 65535) ? m_pair + 1 : 65535;
    else if (g0 ^ g1) m_rr = g0;
  endtask

  task automatic set_req(input int i, input logic w, input logic [15:0] a, input logic [15:0] b);
    pv[i] = 1'b1; pw[i] = w; pa[i] = a; pb[i] = b;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((pv[0] || pv[1]) && n < budget) begin
      cycle();
      n++;
    end
    if (pv[0] || pv[1]) check("drain_timeout", 32'd1, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  // Monitor: every strobe must match the oldest expectation, arriving exactly on its due cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (bus.rsp0_valid) begin
        if (q0.size() == 0) check("rsp0_unexpected", 32'd1, 32'd0);
        else begin
          e = q0.pop_front();
          check("rsp0_cycle", 32'(cyc), 32'(e.due));
          check("rsp0_p", bus.rsp0_p, e.p);
        end
      end else if (q0.size() > 0 && q0[0].due <= cyc) begin
        e = q0.pop_front();
        check("rsp0_missing", 32'd0, 32'd1);
      end
      if (bus.rsp1_valid) begin
        if (q1.size() == 0) check("rsp1_unexpected", 32'd1, 32'd0);
        else begin
          e = q1.pop_front();
          check("rsp1_cycle", 32'(cyc), 32'(e.due));
          check("rsp1_p", bus.rsp1_p, e.p);
        end
      end else if (q1.size() > 0 && q1[0].due <= cyc) begin
        e = q1.pop_front();
        check("rsp1_missing", 32'd0, 32'd1);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_mul_a"}, 32'(bus.mul_a), 32'd0);
    check({tag, "_mul_b"}, 32'(bus.mul_b), 32'd0);
    check({tag, "_mode"}, 32'(bus.mul_para_mode), 32'd0);
    check({tag, "_rsp_valid"}, {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
    check({tag, "_rsp0_p"}, bus.rsp0_p, 32'd0);
    check({tag, "_rsp1_p"}, bus.rsp1_p, 32'd0);
    check({tag, "_pair_cnt"}, 32'(bus.pair_cnt), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      pv[i] = 1'b0; pw[i] = 1'b0; pa[i] = '0; pb[i] = '0; rdy[i] = 1'b0;
    end
    bus.req0_valid = 0; bus.req0_wide = 0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 0; bus.req1_wide = 0; bus.req1_a = '0; bus.req1_b = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Solo narrow on req0.
    set_req(0, 1'b0, 16'h00FF, 16'h00FF);
    cycle();
    check("solo_ready0", 32'(rdy[0]), 32'd1);
    cycle();
    check("solo_mode", 32'(bus.mul_para_mode), 32'd1);
    check("solo_mul_a", 32'(bus.mul_a), 32'h00FF);
    check("solo_mul_b", 32'(bus.mul_b), 32'h00FF);
    idle(2);

    // Two narrow requests in the same cycle.
    set_req(0, 1'b0, 16'h0012, 16'h0034);
    set_req(1, 1'b0, 16'h00AB, 16'h00CD);
    cycle();
`ifdef VAR_BW_MUL_PAIR_EN
    check("pair_both_ready", {30'd0, rdy[1], rdy[0]}, 32'd3);
    cycle();
    check("pair_mode", 32'(bus.mul_para_mode), 32'd1);
    check("pair_mul_a", 32'(bus.mul_a), 32'hAB12);
    check("pair_mul_b", 32'(bus.mul_b), 32'hCD34);
    check("pair_cnt_one", 32'(bus.pair_cnt), 32'd1);
`else
    check("nopair_single_grant", 32'(rdy[0] ^ rdy[1]), 32'd1);
    cycle();
    check("nopair_second_grant", 32'(rdy[0] ^ rdy[1]), 32'd1);
    check("nopair_cnt_zero", 32'(bus.pair_cnt), 32'd0);
`endif
    drain(4);
    idle(2);

    // Wide contention: both held wide, grants must alternate.
    for (int k = 0; k < 4; k++) begin
      logic prev0;
      prev0 = rdy[0];
      if (!pv[0]) set_req(0, 1'b1, 16'h1234, 16'h0002);
      if (!pv[1]) set_req(1, 1'b1, 16'hFFFF, 16'hFFFF);
      cycle();
      if (k > 0) check("wide_alternate", 32'(rdy[0]), 32'(!prev0));
    end
    drain(4);
    idle(2);

    // Narrow operand masking on req1.
    set_req(1, 1'b0, 16'hAB03, 16'hCD05);
    cycle();
    idle(2);

    // Mixed contention with preference on req1: solo req0 first sets it.
    set_req(0, 1'b0, 16'h0007, 16'h0009);
    cycle();
    set_req(0, 1'b1, 16'hBEEF, 16'h0101);
    set_req(1, 1'b0, 16'h0033, 16'h0044);
    cycle();
    check("mixed_first_req1", {30'd0, rdy[1], rdy[0]}, 32'd2);
    cycle();
    check("mixed_then_req0", {30'd0, rdy[1], rdy[0]}, 32'd1);
    idle(3);

    // Reset during the cycle after the handshake discards the request.
    set_req(0, 1'b1, 16'h1234, 16'h0010);
    cycle();
    @(posedge clk);
    #1;
    bus.req0_valid = 0; bus.req1_valid = 0;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    q0.delete();
    q1.delete();
    m_rr = 1'b0;
    m_pair = 0;
    @(negedge clk);
    @(negedge clk);
    check_all_zero("held_reset");
    rst_n = 1'b1;
    idle(4);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pv[i] && $urandom_range(0, 99) < 65)
          set_req(i, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
      end
      cycle();
    end
    drain(8);
    idle(4);
    check("q0_empty", 32'(q0.size()), 32'd0);
    check("q1_empty", 32'(q1.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
